// File: rtl/reu_dma_sequencer.sv
// REU DMA sequencer: takes the C64 bus on Execute and moves bytes between
// C64 memory and expansion RAM (stash / fetch / swap / verify), one bus
// cycle per PHI2 cycle while BA is high. Strobes and DMARW are decoded from
// the registered state so an asynchronous reset removes them at once.
module reu_dma_sequencer #(
    parameter int RAW  = 19,
    parameter int LENW = 16
) (
    input  logic            i_phi2,
    input  logic            i_reset,
    input  logic            i_ba,
    input  logic            i_execute,
    input  logic [1:0]      i_cmd,
    input  logic            i_autoload,
    input  logic            i_fix_c64,
    input  logic            i_fix_ram,
    input  logic [15:0]     i_c64_addr_in,
    input  logic [RAW-1:0]  i_ram_addr_in,
    input  logic [LENW-1:0] i_len_in,
    input  logic            i_irq_en,
    input  logic [7:0]      i_c64_din,
    input  logic [7:0]      i_ram_din,
    output logic            o_dma,
    output logic            o_dmarw,
    output logic [15:0]     o_c64_a,
    output logic [7:0]      o_c64_dout,
    output logic [RAW-1:0]  o_ram_a,
    output logic [7:0]      o_ram_dout,
    output logic            o_ram_rd,
    output logic            o_ram_wr,
    output logic [LENW-1:0] o_len,
    output logic            o_busy,
    output logic            o_end_of_block,
    output logic            o_verify_err,
    output logic            o_irq
);

    localparam logic [1:0] CMD_STASH  = 2'b00;
    localparam logic [1:0] CMD_FETCH  = 2'b01;
    localparam logic [1:0] CMD_SWAP   = 2'b10;
    localparam logic [1:0] CMD_VERIFY = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_XFER,
        S_SWAP_WR,
        S_FINISH
    } state_t;

    state_t          r_state;
    logic            r_dma;
    logic [1:0]      r_cmd;
    logic            r_fix_c64;
    logic            r_fix_ram;
    logic            r_autoload;

    logic [15:0]     r_c64_a;
    logic [RAW-1:0]  r_ram_a;
    logic [LENW-1:0] r_len;
    logic [15:0]     r_c64_a_shadow;
    logic [RAW-1:0]  r_ram_a_shadow;
    logic [LENW-1:0] r_len_shadow;

    // r_ram_dout doubles as the swap holding register for the C64 byte.
    logic [7:0]      r_c64_dout;
    logic [7:0]      r_ram_dout;
    logic            r_end_of_block;
    logic            r_verify_err;

    logic            w_start;
    logic            w_xfer;
    logic            w_swap_wr;
    logic            w_byte_done;
    logic            w_last;
    logic            w_verify_bad;
    logic [15:0]     w_c64_a_step;
    logic [RAW-1:0]  w_ram_a_step;

    assign w_start      = (r_state == S_IDLE) && i_execute;
    assign w_xfer       = (r_state == S_XFER) && i_ba;
    assign w_swap_wr    = (r_state == S_SWAP_WR) && i_ba;
    // A byte completes in XFER for single-cycle commands, in SWAP_WR for swap.
    assign w_byte_done  = (w_xfer && (r_cmd != CMD_SWAP)) || w_swap_wr;
    assign w_last       = (r_len == LENW'(1));
    assign w_verify_bad = w_xfer && (r_cmd == CMD_VERIFY) && (i_c64_din != i_ram_din);
    assign w_c64_a_step = r_fix_c64 ? r_c64_a : r_c64_a + 16'd1;
    assign w_ram_a_step = r_fix_ram ? r_ram_a : r_ram_a + RAW'(1);

    // Sequencer state, bus ownership and per-transfer command latches.
    always_ff @(posedge i_phi2 or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_dma      <= 1'b0;
            r_cmd      <= CMD_STASH;
            r_fix_c64  <= 1'b0;
            r_fix_ram  <= 1'b0;
            r_autoload <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_execute) begin
                        r_state    <= S_START;
                        r_dma      <= 1'b1;
                        r_cmd      <= i_cmd;
                        r_fix_c64  <= i_fix_c64;
                        r_fix_ram  <= i_fix_ram;
                        r_autoload <= i_autoload;
                    end
                end
                S_START: begin
                    r_state <= S_XFER;
                end
                S_XFER: begin
                    if (i_ba) begin
                        if (r_cmd == CMD_SWAP) begin
                            r_state <= S_SWAP_WR;
                        end else if (w_last || w_verify_bad) begin
                            r_state <= S_FINISH;
                        end
                    end
                end
                S_SWAP_WR: begin
                    if (i_ba) begin
                        r_state <= w_last ? S_FINISH : S_XFER;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_dma   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_dma   <= 1'b0;
                end
            endcase
        end
    end

    // Working and shadow address/length registers: load, step, autoload.
    always_ff @(posedge i_phi2 or posedge i_reset) begin
        if (i_reset) begin
            r_c64_a        <= '0;
            r_ram_a        <= '0;
            r_len          <= '0;
            r_c64_a_shadow <= '0;
            r_ram_a_shadow <= '0;
            r_len_shadow   <= '0;
        end else if (w_start) begin
            r_c64_a        <= i_c64_addr_in;
            r_ram_a        <= i_ram_addr_in;
            r_len          <= i_len_in;
            r_c64_a_shadow <= i_c64_addr_in;
            r_ram_a_shadow <= i_ram_addr_in;
            r_len_shadow   <= i_len_in;
        end else if (w_byte_done) begin
            r_c64_a <= w_c64_a_step;
            r_ram_a <= w_ram_a_step;
            // Length parks at 1 on the last byte; 0 wraps to all-ones so a
            // programmed length of 0 moves 2^LENW bytes.
            if (!w_last) begin
                r_len <= r_len - LENW'(1);
            end
        end else if ((r_state == S_FINISH) && r_autoload) begin
            r_c64_a <= r_c64_a_shadow;
            r_ram_a <= r_ram_a_shadow;
            r_len   <= r_len_shadow;
        end
    end

    // Data latches and sticky completion / verify status.
    always_ff @(posedge i_phi2 or posedge i_reset) begin
        if (i_reset) begin
            r_c64_dout     <= '0;
            r_ram_dout     <= '0;
            r_end_of_block <= 1'b0;
            r_verify_err   <= 1'b0;
        end else begin
            if (w_start) begin
                r_end_of_block <= 1'b0;
                r_verify_err   <= 1'b0;
            end
            if (w_byte_done && w_last) begin
                r_end_of_block <= 1'b1;
            end
            if (w_verify_bad) begin
                r_verify_err <= 1'b1;
            end
            if (w_xfer) begin
                case (r_cmd)
                    CMD_STASH: r_ram_dout <= i_c64_din;
                    CMD_FETCH: r_c64_dout <= i_ram_din;
                    CMD_SWAP: begin
                        r_ram_dout <= i_c64_din;
                        r_c64_dout <= i_ram_din;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Bus direction and RAM strobes follow the state; BA=0 suppresses strobes.
    always_comb begin
        o_dmarw  = 1'b1;
        o_ram_rd = 1'b0;
        o_ram_wr = 1'b0;
        if (((r_state == S_XFER) && (r_cmd == CMD_FETCH)) || (r_state == S_SWAP_WR)) begin
            o_dmarw = 1'b0;
        end
        if (w_xfer) begin
            o_ram_wr = (r_cmd == CMD_STASH);
            o_ram_rd = (r_cmd != CMD_STASH);
        end
        if (w_swap_wr) begin
            o_ram_wr = 1'b1;
        end
    end

    // Single-cycle transfers pass the asynchronous read data straight through.
    always_comb begin
        o_c64_dout = r_c64_dout;
        o_ram_dout = r_ram_dout;
        if (w_xfer && (r_cmd == CMD_FETCH)) begin
            o_c64_dout = i_ram_din;
        end
        if (w_xfer && (r_cmd == CMD_STASH)) begin
            o_ram_dout = i_c64_din;
        end
    end

    assign o_dma          = r_dma;
    assign o_c64_a        = r_c64_a;
    assign o_ram_a        = r_ram_a;
    assign o_len          = r_len;
    assign o_busy         = (r_state != S_IDLE);
    assign o_end_of_block = r_end_of_block;
    assign o_verify_err   = r_verify_err;
    assign o_irq          = i_irq_en && (r_end_of_block || r_verify_err);

endmodule
